// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage                                                                |
// | MEM stage of the 8-bit RISC-V pipeline: data memory, branch resolve,     |
// | MEM/WB register. Optional memory-mapped I/O at 0xFF under MEM_IO_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_stage #(
    parameter int PC_SIZE = 10,
    parameter int DEPTH   = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_SIZE-1:0] PC_jump_in,
    input  logic               zero_in,
    input  logic [7:0]         ALU_result_in,
    input  logic [7:0]         write_data_in,
    input  logic               branch_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               mem_to_reg_in,
    input  logic               reg_write_in,
    input  logic [4:0]         write_register_in,
    input  logic [7:0]         io_in,
    output logic               PC_src,
    output logic [PC_SIZE-1:0] PC_branch,
    output logic [7:0]         ex_mem_alu_result,
    output logic [7:0]         read_data_out,
    output logic [7:0]         ALU_result_out,
    output logic               mem_to_reg_out,
    output logic               reg_write_out,
    output logic [4:0]         write_register_out,
    output logic [7:0]         io_out
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0] w_addr;
    logic [7:0]          w_load_data;
    logic                w_is_io;

    logic [7:0]          r_read_data;
    logic [7:0]          r_alu_result;
    logic                r_mem_to_reg;
    logic                r_reg_write;
    logic [4:0]          r_write_register;

    // DEPTH is a power of two, so truncation is the modulo.
    assign w_addr = ALU_result_in[c_ADDR_W-1:0];

    assign PC_src            = branch_in & zero_in;
    assign PC_branch         = PC_jump_in;
    assign ex_mem_alu_result = ALU_result_in;

`ifdef MEM_IO_EN
    logic [7:0] r_io_out;

    // I/O decode uses the full 8-bit address, before any DEPTH wrap.
    assign w_is_io = (ALU_result_in == 8'hFF);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_io_out <= 8'h00;
        end else if (mem_write_in && w_is_io) begin
            r_io_out <= write_data_in;
        end
    end

    assign io_out      = r_io_out;
    assign w_load_data = w_is_io ? io_in : r_mem[w_addr];
`else
    logic w_unused_io;

    assign w_is_io     = 1'b0;
    assign w_unused_io = ^io_in;
    assign io_out      = 8'h00;
    assign w_load_data = r_mem[w_addr];
`endif

    // Memory is never cleared by reset; only stores are blocked.
    always_ff @(posedge clock) begin
        if (!reset && mem_write_in && !w_is_io) begin
            r_mem[w_addr] <= write_data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_data      <= 8'h00;
            r_alu_result     <= 8'h00;
            r_mem_to_reg     <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= 5'd0;
        end else begin
            r_read_data      <= mem_read_in ? w_load_data : 8'h00;
            r_alu_result     <= ALU_result_in;
            r_mem_to_reg     <= mem_to_reg_in;
            r_reg_write      <= reg_write_in;
            r_write_register <= write_register_in;
        end
    end

    assign read_data_out      = r_read_data;
    assign ALU_result_out     = r_alu_result;
    assign mem_to_reg_out     = r_mem_to_reg;
    assign reg_write_out      = r_reg_write;
    assign write_register_out = r_write_register;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage                                                             |
// | Directed self-checking bench for mem_stage (DEPTH 256 and DEPTH 64).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

    logic       clock;
    logic       reset;
    logic [9:0] PC_jump_in;
    logic       zero_in;
    logic [7:0] ALU_result_in;
    logic [7:0] write_data_in;
    logic       branch_in;
    logic       mem_read_in;
    logic       mem_write_in;
    logic       mem_to_reg_in;
    logic       reg_write_in;
    logic [4:0] write_register_in;
    logic [7:0] io_in;

    logic       w_pc_src,   w_pc_src_s;
    logic [9:0] w_pc_br,    w_pc_br_s;
    logic [7:0] w_fwd,      w_fwd_s;
    logic [7:0] w_rd,       w_rd_s;
    logic [7:0] w_alu,      w_alu_s;
    logic       w_m2r,      w_m2r_s;
    logic       w_rw,       w_rw_s;
    logic [4:0] w_wreg,     w_wreg_s;
    logic [7:0] w_io,       w_io_s;

    int checks = 0;
    int errors = 0;

    mem_stage #(.PC_SIZE(10), .DEPTH(256)) dut (
        .clock(clock), .reset(reset), .PC_jump_in(PC_jump_in), .zero_in(zero_in),
        .ALU_result_in(ALU_result_in), .write_data_in(write_data_in),
        .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .write_register_in(write_register_in), .io_in(io_in),
        .PC_src(w_pc_src), .PC_branch(w_pc_br), .ex_mem_alu_result(w_fwd),
        .read_data_out(w_rd), .ALU_result_out(w_alu), .mem_to_reg_out(w_m2r),
        .reg_write_out(w_rw), .write_register_out(w_wreg), .io_out(w_io)
    );

    mem_stage #(.PC_SIZE(10), .DEPTH(64)) dut_small (
        .clock(clock), .reset(reset), .PC_jump_in(PC_jump_in), .zero_in(zero_in),
        .ALU_result_in(ALU_result_in), .write_data_in(write_data_in),
        .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .write_register_in(write_register_in), .io_in(io_in),
        .PC_src(w_pc_src_s), .PC_branch(w_pc_br_s), .ex_mem_alu_result(w_fwd_s),
        .read_data_out(w_rd_s), .ALU_result_out(w_alu_s), .mem_to_reg_out(w_m2r_s),
        .reg_write_out(w_rw_s), .write_register_out(w_wreg_s), .io_out(w_io_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; PC_jump_in = '0; zero_in = 1'b0; ALU_result_in = '0;
        write_data_in = '0; branch_in = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
        write_register_in = '0; io_in = '0;
    endtask

    task automatic store(input logic [7:0] addr, input logic [7:0] data);
        idle();
        ALU_result_in = addr; write_data_in = data; mem_write_in = 1'b1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [4:0] rd);
        idle();
        ALU_result_in = addr; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
        reg_write_in = 1'b1; write_register_in = rd;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();

        // Pre-reset store that must survive a reset with a store pending.
        store(8'h10, 8'h5A); step();

        reset = 1'b1; PC_jump_in = 10'h3FF; zero_in = 1'b1; ALU_result_in = 8'h10;
        write_data_in = 8'hEE; branch_in = 1'b1; mem_read_in = 1'b1;
        mem_write_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        write_register_in = 5'h1F; io_in = 8'hC3;
        step();
        chk("rst_read_data", {8'h0, w_rd}, 16'h0000);
        chk("rst_alu_result", {8'h0, w_alu}, 16'h0000);
        chk("rst_mem_to_reg", {15'h0, w_m2r}, 16'h0000);
        chk("rst_reg_write", {15'h0, w_rw}, 16'h0000);
        chk("rst_write_reg", {11'h0, w_wreg}, 16'h0000);
        chk("rst_io_out", {8'h0, w_io}, 16'h0000);
        chk("rst_pc_src_comb", {15'h0, w_pc_src}, 16'h0001);
        chk("rst_pc_branch_comb", {6'h0, w_pc_br}, 16'h03FF);
        chk("rst_fwd_comb", {8'h0, w_fwd}, 16'h0010);

        load(8'h10, 5'd5); step();
        chk("post_rst_load", {8'h0, w_rd}, 16'h005A);
        chk("post_rst_alu", {8'h0, w_alu}, 16'h0010);
        chk("post_rst_m2r", {15'h0, w_m2r}, 16'h0001);
        chk("post_rst_rw", {15'h0, w_rw}, 16'h0001);
        chk("post_rst_wreg", {11'h0, w_wreg}, 16'h0005);
        chk("small_post_rst_load", {8'h0, w_rd_s}, 16'h005A);

        store(8'h20, 8'hA5); step();
        chk("store_no_read_data", {8'h0, w_rd}, 16'h0000);
        chk("store_alu", {8'h0, w_alu}, 16'h0020);
        chk("store_m2r", {15'h0, w_m2r}, 16'h0000);

        load(8'h20, 5'd9); step();
        chk("load_after_store", {8'h0, w_rd}, 16'h00A5);
        chk("load_after_store_alu", {8'h0, w_alu}, 16'h0020);
        chk("load_after_store_wreg", {11'h0, w_wreg}, 16'h0009);

        store(8'h30, 8'h11); step();
        load(8'h30, 5'd3); mem_write_in = 1'b1; write_data_in = 8'h22; step();
        chk("rw_same_cycle_old", {8'h0, w_rd}, 16'h0011);
        chk("small_rw_same_cycle_old", {8'h0, w_rd_s}, 16'h0011);
        load(8'h30, 5'd3); step();
        chk("rw_following_new", {8'h0, w_rd}, 16'h0022);

        idle(); branch_in = 1'b1; zero_in = 1'b1; PC_jump_in = 10'h155; #1;
        chk("branch_taken", {15'h0, w_pc_src}, 16'h0001);
        chk("branch_target", {6'h0, w_pc_br}, 16'h0155);
        zero_in = 1'b0; #1;
        chk("branch_not_zero", {15'h0, w_pc_src}, 16'h0000);
        branch_in = 1'b0; zero_in = 1'b1; #1;
        chk("no_branch", {15'h0, w_pc_src}, 16'h0000);

        store(8'h45, 8'h77); step();
        load(8'h05, 5'd7); step();
        chk("wrap_depth64", {8'h0, w_rd_s}, 16'h0077);

        // 0x3F is where 0xFF wraps to in the 64-word instance.
        store(8'h3F, 8'h99); step();
        store(8'hFF, 8'h3C); io_in = 8'h81; step();
`ifdef MEM_IO_EN
        chk("io_out_store", {8'h0, w_io}, 16'h003C);
`else
        chk("io_out_store", {8'h0, w_io}, 16'h0000);
`endif
        load(8'hFF, 5'd1); io_in = 8'h81; step();
`ifdef MEM_IO_EN
        chk("load_ff", {8'h0, w_rd}, 16'h0081);
        chk("io_out_hold", {8'h0, w_io}, 16'h003C);
`else
        chk("load_ff", {8'h0, w_rd}, 16'h003C);
        chk("io_out_hold", {8'h0, w_io}, 16'h0000);
`endif
        load(8'h3F, 5'd2); step();
        chk("load_3f", {8'h0, w_rd}, 16'h0099);
`ifdef MEM_IO_EN
        chk("small_ff_not_stored", {8'h0, w_rd_s}, 16'h0099);
`else
        chk("small_ff_wrapped", {8'h0, w_rd_s}, 16'h003C);
`endif

        idle(); reset = 1'b1; step();
        chk("io_out_reset", {8'h0, w_io}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
